// File: rtl/motor_ramp_sequencer.sv
// Drive-command sequencer for the two PWM generators. It slews the left/right duties toward
// commanded targets and forces ramp-to-zero plus dead time before any H-bridge reversal.
module motor_ramp_sequencer #(
  parameter logic [16:0] MAX_DUTY   = 17'd100000,
  parameter logic [16:0] STEP       = 17'd1000,
  parameter int          TICK_DIV   = 50000,
  parameter int          DEAD_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_fwd_l,
  input  logic        cmd_fwd_r,
  input  logic [16:0] cmd_duty_l,
  input  logic [16:0] cmd_duty_r,
  input  logic        estop,
  output logic [16:0] duty_l,
  output logic [16:0] duty_r,
  output logic        l1,
  output logic        l2,
  output logic        r1,
  output logic        r2,
  output logic        busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEAD_TICKS + 1);

  typedef enum logic [2:0] {IDLE, RAMP, DOWN, DEAD, ESTOP} state_t;

  state_t        state, state_next;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [16:0]   tgt_l, tgt_r;
  logic          dir_l, dir_r, dir_valid;
  logic          chg_l, chg_r;
  logic [DW-1:0] dead_cnt;

  logic          accept, differs, reversing, rev_done, on_l, on_r;
  logic [16:0]   cap_l, cap_r, ramp_tgt_l, ramp_tgt_r, next_duty_l, next_duty_r;
  logic          apply_dirs, start_rev, enter_dead, leave_dead;

  // The step is taken from the distance to the target, so it can neither overshoot nor wrap.
  function automatic logic [16:0] step_toward(input logic [16:0] cur, input logic [16:0] tgt);
    logic [16:0] diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      return cur + ((diff > STEP) ? STEP : diff);
    end else begin
      diff = cur - tgt;
      return cur - ((diff > STEP) ? STEP : diff);
    end
  endfunction

  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign cmd_ready = (state == IDLE || state == RAMP) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign cap_l     = (cmd_duty_l > MAX_DUTY) ? MAX_DUTY : cmd_duty_l;
  assign cap_r     = (cmd_duty_r > MAX_DUTY) ? MAX_DUTY : cmd_duty_r;
  assign differs   = (cmd_fwd_l != dir_l) || (cmd_fwd_r != dir_r);

  // A reversing side chases zero until its new direction is applied; its new target waits in tgt.
  assign reversing   = (state == DOWN) || (state == DEAD);
  assign ramp_tgt_l  = (reversing && chg_l) ? '0 : tgt_l;
  assign ramp_tgt_r  = (reversing && chg_r) ? '0 : tgt_r;
  assign next_duty_l = tick ? step_toward(duty_l, ramp_tgt_l) : duty_l;
  assign next_duty_r = tick ? step_toward(duty_r, ramp_tgt_r) : duty_r;
  assign rev_done    = (!chg_l || duty_l == '0) && (!chg_r || duty_r == '0);

  assign on_l = dir_valid && !(state == DEAD && chg_l);
  assign on_r = dir_valid && !(state == DEAD && chg_r);
  assign l1   = on_l && !dir_l;
  assign l2   = on_l && dir_l;
  assign r1   = on_r && !dir_r;
  assign r2   = on_r && dir_r;
  assign busy = (state != IDLE);

  // NOTE: non-blocking assignments make every flop see pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    apply_dirs = 1'b0;
    start_rev  = 1'b0;
    enter_dead = 1'b0;
    leave_dead = 1'b0;
    case (state)
      IDLE:
        if (accept) begin
          if (!dir_valid) begin
            apply_dirs = 1'b1;
            state_next = RAMP;
          end else if (differs) begin
            start_rev  = 1'b1;
            state_next = DOWN;
          end else begin
            state_next = RAMP;
          end
        end
      RAMP:
        if (accept) begin
          if (differs) begin
            start_rev  = 1'b1;
            state_next = DOWN;
          end
        end else if (tick && next_duty_l == tgt_l && next_duty_r == tgt_r) begin
          state_next = IDLE;
        end
      DOWN:
        if (rev_done) begin
          enter_dead = 1'b1;
          state_next = DEAD;
        end
      DEAD:
        if (tick && dead_cnt == DW'(1)) begin
          leave_dead = 1'b1;
          state_next = RAMP;
        end
      ESTOP:
        if (!estop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (estop) state_next = ESTOP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_l    <= '0;
      duty_r    <= '0;
      tgt_l     <= '0;
      tgt_r     <= '0;
      dir_l     <= 1'b0;
      dir_r     <= 1'b0;
      dir_valid <= 1'b0;
      chg_l     <= 1'b0;
      chg_r     <= 1'b0;
      dead_cnt  <= '0;
    end else if (estop) begin
      // Hard stop: no ramp-down, and the next command re-applies direction without dead time.
      duty_l    <= '0;
      duty_r    <= '0;
      tgt_l     <= '0;
      tgt_r     <= '0;
      dir_valid <= 1'b0;
      chg_l     <= 1'b0;
      chg_r     <= 1'b0;
      dead_cnt  <= '0;
    end else begin
      duty_l <= next_duty_l;
      duty_r <= next_duty_r;
      if (accept) begin
        tgt_l <= cap_l;
        tgt_r <= cap_r;
      end
      if (apply_dirs) begin
        dir_l     <= cmd_fwd_l;
        dir_r     <= cmd_fwd_r;
        dir_valid <= 1'b1;
      end
      if (start_rev) begin
        chg_l <= (cmd_fwd_l != dir_l);
        chg_r <= (cmd_fwd_r != dir_r);
      end
      if (enter_dead)                 dead_cnt <= DW'(DEAD_TICKS);
      else if (state == DEAD && tick) dead_cnt <= dead_cnt - DW'(1);
      if (leave_dead) begin
        dir_l <= dir_l ^ chg_l;
        dir_r <= dir_r ^ chg_r;
        chg_l <= 1'b0;
        chg_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Bench for motor_ramp_sequencer: directed scenarios plus random commands, all outputs compared
// every cycle against a behavioural model of the drive rules.
module tb_motor_ramp_sequencer;

  localparam int TICK_DIV   = 10;
  localparam int DEAD_TICKS = 4;
  localparam int STEP       = 1000;
  localparam int MAX_DUTY   = 100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_fwd_l = 1'b0, cmd_fwd_r = 1'b0;
  logic [16:0] cmd_duty_l = '0, cmd_duty_r = '0;
  logic        estop = 1'b0;
  logic        cmd_ready, l1, l2, r1, r2, busy;
  logic [16:0] duty_l, duty_r;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  motor_ramp_sequencer #(
    .MAX_DUTY(17'd100000), .STEP(17'd1000), .TICK_DIV(TICK_DIV), .DEAD_TICKS(DEAD_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fwd_l(cmd_fwd_l), .cmd_fwd_r(cmd_fwd_r), .cmd_duty_l(cmd_duty_l), .cmd_duty_r(cmd_duty_r),
    .estop(estop), .duty_l(duty_l), .duty_r(duty_r),
    .l1(l1), .l2(l2), .r1(r1), .r2(r2), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phases of the drive, integer duties, per-side reversal flags.
  typedef enum {P_IDLE, P_RAMP, P_DOWN, P_DEAD, P_STOP} phase_t;
  phase_t ph;
  int cyc;
  int m_duty[2], m_tgt[2], m_fwd[2], m_rev[2];
  int m_applied, m_dead;

  task automatic model_reset();
    ph = P_IDLE; cyc = 0; m_applied = 0; m_dead = 0;
    m_duty = '{0, 0}; m_tgt = '{0, 0}; m_fwd = '{0, 0}; m_rev = '{0, 0};
  endtask

  function automatic bit m_ready();
    return (ph == P_IDLE || ph == P_RAMP) && !estop;
  endfunction

  function automatic int exp_pins(input int s);
    bit on;
    on = (m_applied != 0) && !(ph == P_DEAD && m_rev[s] != 0);
    return on ? ((m_fwd[s] != 0) ? 1 : 2) : 0;
  endfunction

  task automatic model_edge();
    bit tk, acc, done;
    int want[2], req[2], nd[2];
    int goal, delta;
    tk = (cyc % TICK_DIV) == (TICK_DIV - 1);
    cyc++;
    if (estop) begin
      ph = P_STOP; m_applied = 0; m_dead = 0;
      m_duty = '{0, 0}; m_tgt = '{0, 0}; m_rev = '{0, 0};
      return;
    end
    acc = cmd_valid && (ph == P_IDLE || ph == P_RAMP);
    want[0] = int'(cmd_fwd_l);
    want[1] = int'(cmd_fwd_r);
    req[0] = (int'(cmd_duty_l) > MAX_DUTY) ? MAX_DUTY : int'(cmd_duty_l);
    req[1] = (int'(cmd_duty_r) > MAX_DUTY) ? MAX_DUTY : int'(cmd_duty_r);
    done = 1'b1;
    for (int s = 0; s < 2; s++) begin
      goal  = ((ph == P_DOWN || ph == P_DEAD) && m_rev[s] != 0) ? 0 : m_tgt[s];
      delta = goal - m_duty[s];
      if (delta > STEP) delta = STEP;
      else if (delta < -STEP) delta = -STEP;
      nd[s] = tk ? m_duty[s] + delta : m_duty[s];
      if (m_rev[s] != 0 && m_duty[s] != 0) done = 1'b0;
    end
    case (ph)
      P_IDLE, P_RAMP:
        if (acc) begin
          if (m_applied == 0) begin
            m_fwd = want; m_applied = 1; ph = P_RAMP;
          end else if (want[0] != m_fwd[0] || want[1] != m_fwd[1]) begin
            for (int s = 0; s < 2; s++) m_rev[s] = (want[s] != m_fwd[s]) ? 1 : 0;
            ph = P_DOWN;
          end else begin
            ph = P_RAMP;
          end
        end else if (ph == P_RAMP && tk && nd[0] == m_tgt[0] && nd[1] == m_tgt[1]) begin
          ph = P_IDLE;
        end
      P_DOWN:
        if (done) begin
          ph = P_DEAD; m_dead = DEAD_TICKS;
        end
      P_DEAD:
        if (tk) begin
          m_dead--;
          if (m_dead == 0) begin
            for (int s = 0; s < 2; s++) if (m_rev[s] != 0) m_fwd[s] = 1 - m_fwd[s];
            m_rev = '{0, 0};
            ph = P_RAMP;
          end
        end
      default: ph = P_IDLE;
    endcase
    if (acc) m_tgt = req;
    m_duty = nd;
  endtask

  task automatic compare_all();
    check("duty_l", int'(duty_l), m_duty[0]);
    check("duty_r", int'(duty_r), m_duty[1]);
    check("pins_l", int'({l1, l2}), exp_pins(0));
    check("pins_r", int'({r1, r2}), exp_pins(1));
    check("busy", int'(busy), (ph != P_IDLE) ? 1 : 0);
    check("cmd_ready", int'(cmd_ready), m_ready() ? 1 : 0);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; estop = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    compare_all();
    reset = 1'b0;
  endtask

  task automatic send(input bit fl, input bit fr, input int dl, input int dr);
    bit acc;
    cmd_fwd_l = fl; cmd_fwd_r = fr;
    cmd_duty_l = 17'(dl); cmd_duty_r = 17'(dr);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      acc = m_ready();
      step_cycle();
      if (acc) begin
        cmd_valid = 1'b0;
        return;
      end
    end
    cmd_valid = 1'b0;
    check("send_ready", int'(cmd_ready), 1);
  endtask

  task automatic run_until_duty(input int x);
    for (int i = 0; i < 1000; i++) begin
      step_cycle();
      if (int'(duty_l) == x) return;
    end
    check("wait_duty", int'(duty_l), x);
  endtask

  // Records duty_l / left-pin changes until busy drops.
  int dl_q[$];
  int pl_q[$];
  int off_ticks, ready_off, r_changes;

  task automatic watch(input int budget);
    int prev_d, prev_p, prev_rd, prev_rp;
    bit tk;
    dl_q.delete(); pl_q.delete();
    off_ticks = 0; ready_off = 0; r_changes = 0;
    prev_d = int'(duty_l); prev_p = int'({l1, l2});
    prev_rd = int'(duty_r); prev_rp = int'({r1, r2});
    for (int i = 0; i < budget; i++) begin
      tk = (cyc % TICK_DIV) == (TICK_DIV - 1);
      if ({l1, l2} == 2'b00 && tk) off_ticks++;
      if ({l1, l2} == 2'b00 && cmd_ready) ready_off++;
      step_cycle();
      if (int'(duty_l) != prev_d) dl_q.push_back(int'(duty_l));
      if (int'({l1, l2}) != prev_p) pl_q.push_back(int'({l1, l2}));
      if (int'(duty_r) != prev_rd || int'({r1, r2}) != prev_rp) r_changes++;
      prev_d = int'(duty_l); prev_p = int'({l1, l2});
      prev_rd = int'(duty_r); prev_rp = int'({r1, r2});
      if (!busy) return;
    end
    check("watch_busy", int'(busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Basic ramp up
    do_reset();
    send(1'b1, 1'b1, 2500, 2500);
    check("t1_pins_l", int'({l1, l2}), 1);
    check("t1_pins_r", int'({r1, r2}), 1);
    watch(200);
    check("t1_steps", dl_q.size(), 3);
    if (dl_q.size() == 3) begin
      check("t1_d0", dl_q[0], 1000);
      check("t1_d1", dl_q[1], 2000);
      check("t1_d2", dl_q[2], 2500);
    end
    check("t1_busy", int'(busy), 0);

    // Clamp: approach 100000 from an odd offset so the last step is 500
    send(1'b1, 1'b1, 500, 500);
    watch(200);
    send(1'b1, 1'b1, 120000, 500);
    watch(2000);
    check("t2_final", int'(duty_l), 100000);
    check("t2_steps", dl_q.size(), 100);
    if (dl_q.size() >= 2) check("t2_prev", dl_q[dl_q.size() - 2], 99500);

    // Reversal of the left side only
    do_reset();
    send(1'b1, 1'b1, 3000, 3000);
    watch(300);
    send(1'b0, 1'b1, 2000, 3000);
    watch(1000);
    check("t3_steps", dl_q.size(), 5);
    if (dl_q.size() == 5) begin
      check("t3_d0", dl_q[0], 2000);
      check("t3_d1", dl_q[1], 1000);
      check("t3_d2", dl_q[2], 0);
      check("t3_d3", dl_q[3], 1000);
      check("t3_d4", dl_q[4], 2000);
    end
    check("t3_pin_changes", pl_q.size(), 2);
    if (pl_q.size() == 2) begin
      check("t3_pins_off", pl_q[0], 0);
      check("t3_pins_bwd", pl_q[1], 2);
    end
    check("t3_dead_ticks", off_ticks, DEAD_TICKS);
    check("t3_ready_off", ready_off, 0);
    check("t3_right_still", r_changes, 0);
    check("t3_duty_r", int'(duty_r), 3000);

    // Estop mid-ramp, arriving together with a command
    do_reset();
    send(1'b1, 1'b1, 9000, 9000);
    run_until_duty(5000);
    estop = 1'b1;
    cmd_valid = 1'b1; cmd_fwd_l = 1'b1; cmd_fwd_r = 1'b1;
    cmd_duty_l = 17'd7000; cmd_duty_r = 17'd7000;
    step_cycle();
    cmd_valid = 1'b0;
    check("t4_duty_l", int'(duty_l), 0);
    check("t4_duty_r", int'(duty_r), 0);
    check("t4_pins_l", int'({l1, l2}), 0);
    check("t4_pins_r", int'({r1, r2}), 0);
    check("t4_ready", int'(cmd_ready), 0);
    repeat (3) step_cycle();
    estop = 1'b0;
    repeat (2) step_cycle();
    check("t4_idle", int'(busy), 0);
    send(1'b0, 1'b0, 1000, 1000);
    check("t4_pins_l_bwd", int'({l1, l2}), 2);
    check("t4_pins_r_bwd", int'({r1, r2}), 2);
    watch(200);
    check("t4_no_dead", pl_q.size(), 0);
    check("t4_final", int'(duty_l), 1000);

    // Retarget while ramping
    send(1'b0, 1'b0, 8000, 8000);
    run_until_duty(3000);
    send(1'b0, 1'b0, 1500, 1500);
    watch(200);
    check("t5_steps", dl_q.size(), 2);
    if (dl_q.size() == 2) begin
      check("t5_d0", dl_q[0], 2000);
      check("t5_d1", dl_q[1], 1500);
    end

    // Async reset during the dead interval
    do_reset();
    send(1'b1, 1'b1, 2000, 2000);
    watch(300);
    send(1'b0, 1'b0, 2000, 2000);
    for (int i = 0; i < 500 && ph != P_DEAD; i++) step_cycle();
    check("t6_reached_dead", int'(ph), int'(P_DEAD));
    repeat (15) step_cycle();
    check("t6_pins_off", int'({l1, l2, r1, r2}), 0);
    #2 reset = 1'b1;
    #1;
    check("t6_duty_l", int'(duty_l), 0);
    check("t6_duty_r", int'(duty_r), 0);
    check("t6_pins", int'({l1, l2, r1, r2}), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_ready", int'(cmd_ready), 1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Random commands and estop pulses
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        estop = 1'b1;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_fwd_l = 1'($urandom_range(0, 1));
        cmd_fwd_r = 1'($urandom_range(0, 1));
        cmd_duty_l = 17'($urandom_range(0, 9000));
        cmd_duty_r = 17'($urandom_range(0, 9000));
        repeat ($urandom_range(1, 4)) step_cycle();
        estop = 1'b0;
        cmd_valid = 1'b0;
      end else begin
        send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(95000, 131071)) : int'($urandom_range(0, 9000)),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(95000, 131071)) : int'($urandom_range(0, 9000)));
      end
      repeat ($urandom_range(0, 40)) step_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
